reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised multi-domain reset controller that generalises the two-flop reset synchroniser. An asynchronous active-low reset is synchronised through a configurable number of stages. The block then releases NUM_CHANNELS downstream reset domains one at a time, in index order, with a programmable spacing and a per-channel hold handshake. A software-requested reset re-runs the sequence with a guaranteed minimum assertion width. It sits at chip top, feeding every clock-domain-local reset tree that shares clk.

## Interface
- NUM_CHANNELS, 4, number of reset outputs; ≥1
- SYNC_STAGES, 2, synchroniser depth on reset_n; ≥2
- STAGE_DELAY, 16, clk cycles between successive channel releases; ≥1
- MIN_ASSERT, 8, minimum clk cycles all outputs stay low after a software reset; ≥1
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low; clock clk
- sw_rst_req  input  1  synchronous software reset request, sampled each edge
- hold  input  NUM_CHANNELS  hold[k]=1 blocks release of channel k
- rst_n_out  output  NUM_CHANNELS  per-domain active-low resets; async assert, sync deassert
- busy  output  1  high while any channel is in reset
- done  output  1  high when all channels are released (equals ~busy)

## Operation
- reset_n low: rst_n_out=0, busy=1, done=0 immediately (asynchronous), FSM=HOLD, counters=0, synchroniser cleared.
- FSM states: HOLD, SWRST, RELEASE, RUN.
- HOLD: wait for synchronised reset high → RELEASE, channel index idx=0, cnt=0.
- RELEASE: cnt increments each cycle, saturating at STAGE_DELAY. When cnt has reached STAGE_DELAY and hold[idx]=0, rst_n_out[idx] is set to 1, idx increments and cnt clears. If hold[idx]=1, cnt stays saturated and release happens on the first edge where hold[idx]=0. After channel NUM_CHANNELS-1 is released → RUN.
- RUN: all outputs 1, done=1, busy=0.
- sw_rst_req=1 in RUN, RELEASE or SWRST → all rst_n_out cleared on that edge, FSM=SWRST, cnt=0. A request that arrives during SWRST restarts the MIN_ASSERT window. In HOLD the request is ignored.
- SWRST: cnt counts to MIN_ASSERT → RELEASE with idx=0, cnt=0.
- Outputs only deassert in index order. A lower-index channel is never low while a higher-index channel is high, except asynchronously during reset_n assertion, when all are low anyway.
- Width rules: cnt width is $clog2(max(STAGE_DELAY,MIN_ASSERT)+1). idx width is $clog2(NUM_CHANNELS+1). No wrap-around, because both counters saturate or clear.

## Timing
- Edge 1 is the first rising clk with reset_n high (setup met). The synchronised reset goes high at edge SYNC_STAGES.
- With no holds, rst_n_out[k] rises at edge SYNC_STAGES + (k+1)*STAGE_DELAY. done rises on the same edge as the last channel.
- Software reset sampled at edge E: all outputs are low after edge E. With no holds, channel k rises at edge E + MIN_ASSERT + (k+1)*STAGE_DELAY.
- A hold of h cycles on channel k beyond its due edge delays channel k and every later channel by h cycles.
- reset_n assertion mid-sequence or mid-SWRST aborts everything asynchronously. Deassertion restarts from HOLD.
- All outputs are registered. No combinational path from any input to rst_n_out except the asynchronous clear.

## Structure
- reset_pkg: FSM state enum (HOLD, SWRST, RELEASE, RUN) and a max() helper function for counter sizing.
- Sub-module reset_sync: a SYNC_STAGES-deep, 1-bit synchroniser with async clear and input tied high. It is instantiated once.
- The top level holds the FSM, cnt, idx and per-channel output flops. The output flops are asynchronously cleared by reset_n.

## Test plan
All scenarios use NUM_CHANNELS=3, SYNC_STAGES=2, STAGE_DELAY=4 and MIN_ASSERT=3.
- Power-on, hold=0: reset_n rises before edge 1 → rst_n_out goes 001 at edge 6, 011 at edge 10, 111 at edge 14, with done=1 from edge 14.
- sw_rst_req pulse at edge 20 in RUN → rst_n_out=000 after edge 20, 001 at edge 27, 011 at edge 31, 111 at edge 35.
- hold[1]=1 from reset until edge 15 → ch0 rises at edge 6, ch1 at edge 15, ch2 at edge 19.
- reset_n drops between edges 8 and 9 (ch0 high) → rst_n_out=000 immediately. After reset_n re-rises, the sequence matches scenario 1 relative to the new edge 1.
- sw_rst_req at edge 20 and again at edge 22 → ch0 rises at edge 29 (window restarted), ch2 at edge 37.
- sw_rst_req held high throughout reset and HOLD → no effect until RELEASE. Then each cycle the request is high, FSM re-enters SWRST and outputs stay 000.

Source files
------------

// File: rtl/reset_pkg.sv
// reset_pkg: sequencer FSM states and counter sizing helper
package reset_pkg;
  typedef enum logic [1:0] {HOLD, SWRST, RELEASE, RUN} state_e;
  function automatic int max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-clear, sync-release 1-bit synchroniser with input tied high
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= (sync_q << 1) | STAGES'(1);
  assign sync_o = sync_q[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises reset_n and releases per-domain resets in index order
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STAGE_DELAY  = 16,
  parameter int MIN_ASSERT   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sw_rst_req,
  input  logic [NUM_CHANNELS-1:0] hold,
  output logic [NUM_CHANNELS-1:0] rst_n_out,
  output logic                    busy,
  output logic                    done
);
  localparam int CW = $clog2(max(STAGE_DELAY, MIN_ASSERT) + 1);
  localparam int IW = $clog2(NUM_CHANNELS + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] rst_q, rst_d, sel;
  logic sync, due, go, last;
  // the state register forms the final synchroniser stage, so the chain is one shorter
  reset_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .sync_o(sync)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    sel     = NUM_CHANNELS'(1) << idx_q;
    due     = int'(cnt_q) + 1 >= STAGE_DELAY;
    go      = due && !(|(hold & sel));
    last    = int'(idx_q) == NUM_CHANNELS - 1;
    if (state_q != HOLD && sw_rst_req) begin
      state_d = SWRST;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
    end else begin
      case (state_q)
        HOLD: state_d = sync ? RELEASE : HOLD;
        SWRST: begin
          state_d = int'(cnt_q) + 1 >= MIN_ASSERT ? RELEASE : SWRST;
          cnt_d   = int'(cnt_q) + 1 >= MIN_ASSERT ? '0 : cnt_q + CW'(1);
          idx_d   = '0;
        end
        RELEASE: begin
          // cnt saturates while a hold stalls the current channel
          state_d = go && last ? RUN : RELEASE;
          rst_d   = go ? rst_q | sel : rst_q;
          idx_d   = go ? idx_q + IW'(1) : idx_q;
          cnt_d   = go ? '0 : (int'(cnt_q) == STAGE_DELAY ? cnt_q : cnt_q + CW'(1));
        end
        default: ;
      endcase
    end
  end
  assign rst_n_out = rst_q;
  assign done      = &rst_q;
  assign busy      = ~done;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed edge-accurate checks of the reset sequencer
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sw_rst_req = 1'b0;
  logic [2:0] hold = 3'b000;
  logic [2:0] rst_n_out;
  logic busy, done;
  int e = 0;
  int errors = 0;
  int checks = 0;
  reset_sequencer #(
    .NUM_CHANNELS(3),
    .SYNC_STAGES(2),
    .STAGE_DELAY(4),
    .MIN_ASSERT(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_rst_req(sw_rst_req),
    .hold(hold),
    .rst_n_out(rst_n_out),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic go_to(input int t);
    while (e < t) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask
  task automatic chk(input string tag, input logic [2:0] exp);
    checks++;
    assert (rst_n_out === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d rst_n_out=%b expected=%b", tag, e, rst_n_out, exp);
    end
    checks++;
    assert (done === &exp) else begin
      errors++;
      $error("FAIL %s edge=%0d done=%b expected=%b", tag, e, done, &exp);
    end
    checks++;
    assert (busy === ~&exp) else begin
      errors++;
      $error("FAIL %s edge=%0d busy=%b expected=%b", tag, e, busy, ~&exp);
    end
  endtask
  task automatic assert_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
  endtask
  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    e = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 3'b000);
    release_reset();
    go_to(5);  chk("po_e5", 3'b000);
    go_to(6);  chk("po_e6", 3'b001);
    go_to(9);  chk("po_e9", 3'b001);
    go_to(10); chk("po_e10", 3'b011);
    go_to(13); chk("po_e13", 3'b011);
    go_to(14); chk("po_e14", 3'b111);
    go_to(19); chk("po_e19", 3'b111);
    sw_rst_req = 1'b1;
    go_to(20); chk("sw_e20", 3'b000);
    sw_rst_req = 1'b0;
    go_to(26); chk("sw_e26", 3'b000);
    go_to(27); chk("sw_e27", 3'b001);
    go_to(30); chk("sw_e30", 3'b001);
    go_to(31); chk("sw_e31", 3'b011);
    go_to(34); chk("sw_e34", 3'b011);
    go_to(35); chk("sw_e35", 3'b111);
    assert_reset();
    chk("async_run", 3'b000);
    hold = 3'b010;
    release_reset();
    go_to(6);  chk("hold_e6", 3'b001);
    go_to(10); chk("hold_e10", 3'b001);
    go_to(14); chk("hold_e14", 3'b001);
    hold = 3'b000;
    go_to(15); chk("hold_e15", 3'b011);
    go_to(18); chk("hold_e18", 3'b011);
    go_to(19); chk("hold_e19", 3'b111);
    assert_reset();
    release_reset();
    go_to(8);  chk("abort_e8", 3'b001);
    assert_reset();
    chk("abort_async", 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_held", 3'b000);
    release_reset();
    go_to(5);  chk("re_e5", 3'b000);
    go_to(6);  chk("re_e6", 3'b001);
    go_to(10); chk("re_e10", 3'b011);
    go_to(14); chk("re_e14", 3'b111);
    go_to(19);
    sw_rst_req = 1'b1;
    go_to(20); chk("dbl_e20", 3'b000);
    sw_rst_req = 1'b0;
    go_to(21);
    sw_rst_req = 1'b1;
    go_to(22); chk("dbl_e22", 3'b000);
    sw_rst_req = 1'b0;
    go_to(28); chk("dbl_e28", 3'b000);
    go_to(29); chk("dbl_e29", 3'b001);
    go_to(33); chk("dbl_e33", 3'b011);
    go_to(36); chk("dbl_e36", 3'b011);
    go_to(37); chk("dbl_e37", 3'b111);
    assert_reset();
    sw_rst_req = 1'b1;
    release_reset();
    go_to(2);  chk("swhi_e2", 3'b000);
    go_to(6);  chk("swhi_e6", 3'b000);
    go_to(14); chk("swhi_e14", 3'b000);
    go_to(20); chk("swhi_e20", 3'b000);
    sw_rst_req = 1'b0;
    go_to(26); chk("swhi_e26", 3'b000);
    go_to(27); chk("swhi_e27", 3'b001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
